fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_wfifo.sv | 55 +++++
 rtl/fb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, write-entry layout and fill FSM states.
// Used by the arbiter and by the VGA-side blocks.
package fb_pkg;
  localparam int ROW_W  = 9;
  localparam int COL_W  = 10;
  localparam int PIX_W  = 12;
  localparam int H_PIX  = 640;
  localparam int V_PIX  = 480;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] pix;
  } wr_ent_t;

  typedef enum logic {FILL_IDLE, FILL_RUN} fill_st_t;

  // Row/column are simply concatenated, so the address space has holes past col 639.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/fb_wfifo.sv
// Synchronous write buffer: a push is visible at the output one cycle later.
// push is ignored while full and pop while empty; the caller drives ready from full.
module fb_wfifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/fb_arbiter.sv
// Pixel-RAM owner mux (display read > fill engine > write FIFO) with the screen-fill FSM.
// Display reads are zero-latency; writers stall while vga_rdn is low and wr_ready drops when the FIFO is full.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  vga_clk,
  input  logic                  rst,
  input  logic                  vga_rdn,
  input  logic [ROW_W-1:0]      vga_row,
  input  logic [COL_W-1:0]      vga_col,
  output logic [PIX_W-1:0]      vga_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [COL_W-1:0]      wr_col,
  input  logic [PIX_W-1:0]      wr_data,
  input  logic                  fill_start,
  input  logic [PIX_W-1:0]      fill_color,
  output logic                  fill_busy,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [PIX_W-1:0]      ram_wdata,
  input  logic [PIX_W-1:0]      ram_rdata
);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_PIX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIX - 1);

  fill_st_t         st_q;
  logic             fill_busy_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [PIX_W-1:0] color_q;

  wr_ent_t push_ent, pop_ent;
  logic    fifo_full, fifo_empty, fifo_pop;
  logic    fill_own;

  assign push_ent  = '{row: wr_row, col: wr_col, pix: wr_data};
  assign wr_ready  = ~fifo_full;
  assign fill_busy = fill_busy_q;
  assign vga_data  = ram_rdata;
  assign fill_own  = vga_rdn & fill_busy_q;
  assign fifo_pop  = vga_rdn & ~fill_busy_q & ~fifo_empty & ~rst;

  fb_wfifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .W          ($bits(wr_ent_t))
  ) u_wfifo (
    .clk   (vga_clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (fifo_pop),
    .din   (push_ent),
    .dout  (pop_ent),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Display read wins combinationally; writes are masked during reset.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!vga_rdn) begin
      ram_addr = pix_addr(vga_row, vga_col);
    end else if (fill_busy_q) begin
      ram_addr  = pix_addr(row_q, col_q);
      ram_we    = ~rst;
      ram_wdata = color_q;
    end else if (!fifo_empty) begin
      ram_addr  = pix_addr(pop_ent.row, pop_ent.col);
      ram_we    = ~rst;
      ram_wdata = pop_ent.pix;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      st_q        <= FILL_IDLE;
      fill_busy_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      color_q     <= '0;
    end else begin
      case (st_q)
        FILL_IDLE: begin
          if (fill_start) begin
            st_q        <= FILL_RUN;
            fill_busy_q <= 1'b1;
            color_q     <= fill_color;
            row_q       <= '0;
            col_q       <= '0;
          end
        end
        FILL_RUN: begin
          // Position only advances on cycles where the fill actually wrote.
          if (fill_own) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                st_q        <= FILL_IDLE;
                fill_busy_q <= 1'b0;
                row_q       <= '0;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: begin
          st_q        <= FILL_IDLE;
          fill_busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
